// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 bit-mux channel: registered one-hot grant,
// mux select and valid, with each tenure bounded to MAX_HOLD cycles.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       dout
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       gnt_d;
  logic [1:0]       sel_d;
  logic             valid_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic             grant_new;

  // Round-robin pick: search starts just after the last owner and wraps to it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      sel      <= sel_d;
      valid    <= valid_d;
      hold_cnt <= hold_cnt_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt;
    sel_d      = sel;
    valid_d    = valid;
    hold_cnt_d = hold_cnt;
    last_d     = last_q;
    grant_new  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) grant_new = 1'b1;
      end
      BUSY: begin
        // Tenure ends on owner drop or timeout; any pending request is served at the same edge.
        if (!req[sel] || (hold_cnt == CNT_LAST)) begin
          if (|req) begin
            grant_new = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      state_d    = BUSY;
      gnt_d      = 4'b0001 << win_idx;
      sel_d      = win_idx;
      valid_d    = 1'b1;
      hold_cnt_d = '0;
      last_d     = win_idx;
    end
  end

  assign dout = valid & din[sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level round-robin reference model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       dout;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner = -1 when nobody holds the channel.
  int m_owner = -1;
  int m_sel   = 0;
  int m_last  = 3;
  int m_cnt   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .valid(valid), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input int last, input logic [3:0] q);
    for (int i = 1; i <= 4; i++) begin
      if (q[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    logic       v;
    v = (m_owner >= 0);
    g = v ? (4'b0001 << m_owner) : 4'b0000;
    return {g, 2'(m_sel), v, v & din[m_sel]};
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle after it.
  task automatic tick(input logic r, input logic [3:0] q, input logic [3:0] d);
    @(negedge clk);
    rst = r; req = q; din = d;
    @(posedge clk);
    if (r) begin
      m_owner = -1; m_sel = 0; m_last = 3; m_cnt = 0;
    end else if (m_owner < 0 || !q[m_owner] || m_cnt == MAX_HOLD - 1) begin
      if (q != 4'b0000) begin
        m_owner = rr_pick(m_last, q);
        m_last  = m_owner;
        m_sel   = m_owner;
        m_cnt   = 0;
      end else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b0000, 4'b0000);
    tick(1'b1, 4'b0000, 4'b0000);
    total++;
    if ({gnt, sel, valid, dout} !== 8'b0000_00_0_0) begin
      bad++; $display("FAIL reset_state: got %b want %b", {gnt, sel, valid, dout}, 8'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b0000, 4'b1111);
      total++;
      if ({gnt, sel, valid, dout} !== 8'b0000_00_0_0) begin
        bad++; $display("FAIL idle_hold[%0d]: got %b want %b", i, {gnt, sel, valid, dout}, 8'b0);
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'b0100, 4'b0100);
      total++;
      if ({gnt, sel, valid, dout} !== 8'b0100_10_1_1) begin
        bad++; $display("FAIL single_grant[%0d]: got %b want %b", i, {gnt, sel, valid, dout}, 8'b0100_10_1_1);
      end
    end
    tick(1'b0, 4'b0000, 4'b0100);
    total++;
    if ({gnt, sel, valid, dout} !== 8'b0000_10_0_0) begin
      bad++; $display("FAIL single_release: got %b want %b", {gnt, sel, valid, dout}, 8'b0000_10_0_0);
    end
  endtask

  task automatic test_all_req();
    int prev, run, cur, n_tenure;
    tick(1'b1, 4'b0000, 4'b0000);
    prev = -1; run = 0; n_tenure = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 4'b1111, 4'($urandom));
      total++;
      if ({gnt, sel, valid, dout} !== exp_vec()) begin
        bad++; $display("FAIL all_req_model[%0d]: got %b want %b", c, {gnt, sel, valid, dout}, exp_vec());
      end
      cur = idx_of(gnt);
      if (cur == prev) begin
        run++;
      end else begin
        total++;
        if (cur != n_tenure % 4) begin
          bad++; $display("FAIL all_req_order[%0d]: got owner %0d want %0d", c, cur, n_tenure % 4);
        end
        if (prev >= 0) begin
          total++;
          if (run != MAX_HOLD) begin
            bad++; $display("FAIL all_req_tenure[%0d]: got %0d cycles want %0d", prev, run, MAX_HOLD);
          end
        end
        n_tenure++;
        prev = cur; run = 1;
      end
    end
    total++;
    if (n_tenure != 5) begin
      bad++; $display("FAIL all_req_count: got %0d tenures want 5", n_tenure);
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      tick(1'b0, 4'b0001, 4'($urandom));
      total++;
      if ({gnt, sel, valid} !== 7'b0001_00_1 || dout !== din[0]) begin
        bad++; $display("FAIL solo_regrant[%0d]: got %b/%b want %b/%b", c, {gnt, sel, valid}, dout, 7'b0001_00_1, din[0]);
      end
    end
  endtask

  task automatic test_drop();
    tick(1'b1, 4'b0000, 4'b0000);
    tick(1'b0, 4'b0010, 4'b0000);
    tick(1'b0, 4'b1011, 4'b0010);
    total++;
    if ({gnt, sel, valid, dout} !== 8'b0010_01_1_1) begin
      bad++; $display("FAIL drop_owner1: got %b want %b", {gnt, sel, valid, dout}, 8'b0010_01_1_1);
    end
    tick(1'b0, 4'b1001, 4'b1000);
    total++;
    if ({gnt, sel, valid, dout} !== 8'b1000_11_1_1) begin
      bad++; $display("FAIL drop_next3: got %b want %b", {gnt, sel, valid, dout}, 8'b1000_11_1_1);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b0100, 4'b0100);
    tick(1'b1, 4'b0100, 4'b0100);
    total++;
    if ({gnt, sel, valid, dout} !== 8'b0000_00_0_0) begin
      bad++; $display("FAIL mid_reset: got %b want %b", {gnt, sel, valid, dout}, 8'b0);
    end
    tick(1'b0, 4'b1111, 4'b0001);
    total++;
    if ({gnt, sel, valid, dout} !== 8'b0001_00_1_1) begin
      bad++; $display("FAIL post_reset_win: got %b want %b", {gnt, sel, valid, dout}, 8'b0001_00_1_1);
    end
  endtask

  task automatic test_random();
    logic [3:0] q;
    logic       r;
    q = 4'b0000;
    tick(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) q[k] = ~q[k];
      end
      r = ($urandom_range(0, 63) == 0);
      tick(r, q, 4'($urandom));
      total++;
      if ({gnt, sel, valid, dout} !== exp_vec()) begin
        bad++; $display("FAIL random[%0d]: req=%b got %b want %b", c, q, {gnt, sel, valid, dout}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
